// File: rtl/fetch_byte_queue.sv
// Circular byte queue between I-cache fetch and the opcode decoder.
// Accepts aligned fetch blocks, presents a decode window at the current PC, advances on consume.
module fetch_byte_queue #(
   parameter  int DEPTH_BYTES = 32,
   parameter  int FILL_BYTES  = 8,
   parameter  int WIN_BYTES   = 16,
   localparam int PTR_W       = $clog2(DEPTH_BYTES),
   localparam int CNT_W       = PTR_W + 1,
   localparam int WB_W        = $clog2(WIN_BYTES) + 1
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   flush,
   input  logic [63:0]            flush_pc,
   input  logic                   fill_valid,
   output logic                   fill_ready,
   input  logic [8*FILL_BYTES-1:0] fill_data,
   output logic [8*WIN_BYTES-1:0]  win_data,
   output logic [WB_W-1:0]         win_bytes,
   output logic [63:0]            win_pc,
   input  logic                   consume_valid,
   input  logic [3:0]             consume_len,
   output logic [CNT_W-1:0]        occupancy
);

   logic [7:0]       mem [DEPTH_BYTES];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_n;
   logic [CNT_W-1:0] cons;
   logic [63:0]      pc;
   logic             fill_fire;

   // Fill handshake: a block transfers on any rising edge where fill_valid and
   // fill_ready are both high; fill_ready depends only on the registered count,
   // so a same-cycle consume never opens room for a fill.
   assign fill_ready = (count <= CNT_W'(DEPTH_BYTES - FILL_BYTES));
   assign fill_fire  = fill_valid & fill_ready;

   assign win_bytes = (count > CNT_W'(WIN_BYTES)) ? WB_W'(WIN_BYTES) : WB_W'(count);
   assign win_pc    = pc;
   assign occupancy = count;

   // Over-long consume is clamped to what the window actually holds.
   always_comb begin
      cons = '0;
      if (consume_valid) begin
         if (CNT_W'(consume_len) > CNT_W'(win_bytes))
            cons = CNT_W'(win_bytes);
         else
            cons = CNT_W'(consume_len);
      end
   end

   always_comb begin
      count_n = count + (fill_fire ? CNT_W'(FILL_BYTES) : '0) - cons;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         pc     <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         pc     <= flush_pc;
      end else begin
         count  <= count_n;
         rd_ptr <= rd_ptr + PTR_W'(cons);
         pc     <= pc + 64'(cons);
         if (fill_fire)
            wr_ptr <= wr_ptr + PTR_W'(FILL_BYTES);
      end
   end

   // Storage needs no reset: count masks every stale byte out of the window.
   always_ff @(posedge clk) begin
      if (fill_fire && !flush) begin
         for (int j = 0; j < FILL_BYTES; j++)
            mem[wr_ptr + PTR_W'(j)] <= fill_data[8*j +: 8];
      end
   end

   // Pointer arithmetic wraps modulo DEPTH, so the window crosses the wrap point freely.
   for (genvar i = 0; i < WIN_BYTES; i++) begin : g_win
      logic [PTR_W-1:0] idx;
      assign idx = rd_ptr + PTR_W'(i);
      assign win_data[8*i +: 8] = (WB_W'(i) < win_bytes) ? mem[idx] : 8'h00;
   end

   always_ff @(posedge clk) begin
      if (reset_n && !flush && consume_valid) begin
         assert (CNT_W'(consume_len) <= CNT_W'(win_bytes))
            else $warning("decoder consumed %0d bytes with only %0d in window; clamped",
                          consume_len, win_bytes);
      end
   end

endmodule
